// File: rtl/conv_256pe.sv
// conv_256pe: 256-lane signed MAC array with per-lane accumulation windows and 8-bit saturating output.
// Define CONV_RELU_EN to clamp negative lane results to zero before saturation.
module conv_256pe #(
  parameter int NUM_PE    = 256,
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 24,
  parameter int OUT_SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_PE*DATA_W-1:0] IFM,
  input  logic [DATA_W-1:0]        Weight,
  input  logic [NUM_PE-1:0]        PE_en,
  input  logic [NUM_PE-1:0]        PE_finish,
  output logic [NUM_PE*DATA_W-1:0] OFM,
  output logic                     valid
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  function automatic logic [DATA_W-1:0] quant(input logic signed [ACC_W-1:0] x);
    logic signed [ACC_W-1:0] s;
    s = x >>> OUT_SHIFT;
`ifdef CONV_RELU_EN
    if (s < 0) s = '0;
`else
    if (s < SAT_MIN) s = SAT_MIN;
`endif
    if (s > SAT_MAX) s = SAT_MAX;
    return s[DATA_W-1:0];
  endfunction

  logic signed [DATA_W-1:0] weight_s;
  logic [NUM_PE-1:0]        fin_hit;
  logic                     valid_q, valid_d;

  assign weight_s = Weight;

  for (genvar g = 0; g < NUM_PE; g++) begin : g_pe
    logic signed [DATA_W-1:0]   ifm_s;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    term, sum, acc_q, acc_d;
    logic                       active_q, active_d;
    logic [DATA_W-1:0]          ofm_q, ofm_d;

    assign ifm_s = IFM[g*DATA_W +: DATA_W];
    assign prod  = ifm_s * weight_s;
    assign term  = ACC_W'(prod);
    assign sum   = acc_q + term;

    // Finish takes priority when active: the finishing cycle's product closes the old
    // window, and a coincident enable only keeps the PE active with an empty sum.
    always_comb begin
      acc_d    = acc_q;
      active_d = active_q;
      ofm_d    = ofm_q;
      if (PE_finish[g] && active_q) begin
        ofm_d    = quant(sum);
        acc_d    = '0;
        active_d = PE_en[g];
      end else if (PE_en[g]) begin
        acc_d    = term;
        active_d = 1'b1;
      end else if (active_q) begin
        acc_d = sum;
      end
    end

    assign fin_hit[g] = PE_finish[g] & active_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        acc_q    <= '0;
        active_q <= 1'b0;
        ofm_q    <= '0;
      end else begin
        acc_q    <= acc_d;
        active_q <= active_d;
        ofm_q    <= ofm_d;
      end
    end

    assign OFM[g*DATA_W +: DATA_W] = ofm_q;
  end

  always_comb begin
    valid_d = |fin_hit;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) valid_q <= 1'b0;
    else          valid_q <= valid_d;
  end

  assign valid = valid_q;

endmodule

// File: tb/tb_conv_256pe.sv
// Directed testbench for conv_256pe: windows driven on the falling edge, results checked on the next falling edge.
module tb_conv_256pe;
  localparam int NUM_PE = 256;
  localparam int DATA_W = 8;
  localparam int W_ALL  = NUM_PE * DATA_W;

  logic              clk;
  logic              reset_n;
  logic [W_ALL-1:0]  IFM;
  logic [DATA_W-1:0] Weight;
  logic [NUM_PE-1:0] PE_en;
  logic [NUM_PE-1:0] PE_finish;
  logic [W_ALL-1:0]  OFM;
  logic              valid;

  int n_assert = 0;
  int n_fail   = 0;

  conv_256pe #(
    .NUM_PE   (NUM_PE),
    .DATA_W   (DATA_W),
    .ACC_W    (24),
    .OUT_SHIFT(0)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .IFM      (IFM),
    .Weight   (Weight),
    .PE_en    (PE_en),
    .PE_finish(PE_finish),
    .OFM      (OFM),
    .valid    (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [W_ALL-1:0] exp);
    int first;
    first = -1;
    for (int i = 0; i < NUM_PE; i++)
      if (first < 0 && OFM[i*DATA_W +: DATA_W] !== exp[i*DATA_W +: DATA_W]) first = i;
    if (first < 0) first = 0;
    n_assert++;
    assert (OFM === exp) else begin
      n_fail++;
      $error("FAIL %s: lane %0d observed %h expected %h", tag, first,
             OFM[first*DATA_W +: DATA_W], exp[first*DATA_W +: DATA_W]);
    end
  endtask

  // Enable for one cycle, 'plain' accumulate cycles, then finish; returns on the falling
  // edge after the finishing rising edge, with PE_finish already released.
  task automatic window(input logic [7:0] ifm_b, input logic [7:0] w,
                        input logic [NUM_PE-1:0] en, input logic [NUM_PE-1:0] fin,
                        input int plain);
    IFM    = {NUM_PE{ifm_b}};
    Weight = w;
    PE_en  = en;
    @(negedge clk);
    PE_en = '0;
    repeat (plain) @(negedge clk);
    PE_finish = fin;
    @(negedge clk);
    PE_finish = '0;
  endtask

  logic [W_ALL-1:0] exp_w;
  int               valid_hits;

  initial begin
    reset_n   = 1'b0;
    IFM       = '0;
    Weight    = '0;
    PE_en     = '0;
    PE_finish = '0;
    repeat (3) @(negedge clk);
    chk_word("reset_ofm", '0);
    chk_bit("reset_valid", valid, 1'b0);

    // Finish without any enable must never produce valid.
    reset_n    = 1'b1;
    PE_finish  = '1;
    valid_hits = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (valid !== 1'b0) valid_hits++;
    end
    PE_finish = '0;
    n_assert++;
    assert (valid_hits === 0) else begin
      n_fail++;
      $error("FAIL idle_finish_valid: observed %0d pulses expected 0", valid_hits);
    end
    chk_word("idle_finish_ofm", '0);

    // 27 x (1*2) = 54
    window(8'h01, 8'h02, '1, '1, 25);
    chk_word("sum54_ofm", {NUM_PE{8'h36}});
    chk_bit("sum54_valid", valid, 1'b1);
    @(negedge clk);
    chk_bit("sum54_valid_drop", valid, 1'b0);
    chk_word("sum54_hold", {NUM_PE{8'h36}});

    // 27 x (-1*1) = -27
    window(8'hFF, 8'h01, '1, '1, 25);
`ifdef CONV_RELU_EN
    chk_word("neg27_ofm", {NUM_PE{8'h00}});
`else
    chk_word("neg27_ofm", {NUM_PE{8'hE5}});
`endif
    chk_bit("neg27_valid", valid, 1'b1);

    window(8'h7F, 8'h7F, '1, '1, 25);
    chk_word("sat_pos_ofm", {NUM_PE{8'h7F}});

    window(8'h80, 8'h7F, '1, '1, 25);
`ifdef CONV_RELU_EN
    exp_w = {NUM_PE{8'h00}};
`else
    exp_w = {NUM_PE{8'h80}};
`endif
    chk_word("sat_neg_ofm", exp_w);

    // Only lane 0 opens and closes a window; all other lanes keep the saturated value.
    window(8'h01, 8'h01, {{(NUM_PE-1){1'b0}}, 1'b1}, {{(NUM_PE-1){1'b0}}, 1'b1}, 25);
    exp_w[7:0] = 8'h1B;
    chk_word("lane0_only_ofm", exp_w);
    chk_bit("lane0_only_valid", valid, 1'b1);
    @(negedge clk);
    chk_bit("lane0_only_valid_drop", valid, 1'b0);

    // Back-to-back: second window's enable lands on the cycle right after finish.
    window(8'h02, 8'h01, '1, '1, 25);
    chk_word("b2b_first_ofm", {NUM_PE{8'h36}});
    chk_bit("b2b_first_valid", valid, 1'b1);
    window(8'h01, 8'h01, '1, '1, 25);
    chk_word("b2b_second_ofm", {NUM_PE{8'h1B}});
    chk_bit("b2b_second_valid", valid, 1'b1);

    // Coincident enable+finish: 27 x 3 = 81 closes the old window, the new one starts empty
    // and then collects 26 x 1 = 26.
    IFM    = {NUM_PE{8'h01}};
    Weight = 8'h03;
    PE_en  = '1;
    @(negedge clk);
    PE_en = '0;
    repeat (25) @(negedge clk);
    PE_en     = '1;
    PE_finish = '1;
    @(negedge clk);
    PE_en     = '0;
    PE_finish = '0;
    chk_word("overlap_old_ofm", {NUM_PE{8'h51}});
    chk_bit("overlap_old_valid", valid, 1'b1);
    Weight = 8'h01;
    repeat (25) @(negedge clk);
    PE_finish = '1;
    @(negedge clk);
    PE_finish = '0;
    chk_word("overlap_new_ofm", {NUM_PE{8'h1A}});
    chk_bit("overlap_new_valid", valid, 1'b1);

    // Reset mid-window discards it; the later finish is ignored.
    IFM    = {NUM_PE{8'h01}};
    Weight = 8'h01;
    PE_en  = '1;
    @(negedge clk);
    PE_en = '0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_word("midreset_async_ofm", '0);
    chk_bit("midreset_async_valid", valid, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    PE_finish = '1;
    @(negedge clk);
    PE_finish = '0;
    chk_bit("midreset_finish_valid", valid, 1'b0);
    chk_word("midreset_finish_ofm", '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
